// File: rtl/pipe_reg_chain_pkg.sv
// rtl/pipe_reg_chain_pkg.sv - shared constants and helpers for the pipeline register chain
package pipe_reg_chain_pkg;

    localparam int WORD           = 32;
    localparam int PIPE_MAX_DEPTH = 8;

    // Width needed to count 0..d valid stages inclusive.
    function automatic int occ_w(input int d);
        return $clog2(d + 1);
    endfunction

endpackage

// File: rtl/pipe_reg_chain_pipe_stage.sv
// rtl/pipe_reg_chain_pipe_stage.sv - one data+valid stage with reset, flush and stall
module pipe_stage
    import pipe_reg_chain_pkg::*;
#(
    parameter int               WIDTH      = WORD,
    parameter logic [WIDTH-1:0] RESET_VAL  = '0,
    parameter bit               FLUSH_DATA = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en_i,
    input  logic             flush_i,
    input  logic             valid_i,
    input  logic [WIDTH-1:0] data_i,
    output logic             valid_o,
    output logic [WIDTH-1:0] data_o
);

    logic             valid_q, valid_d;
    logic [WIDTH-1:0] data_q, data_d;

    // Flush outranks stall; reset is handled in the register itself.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (flush_i) begin
            valid_d = 1'b0;
            if (FLUSH_DATA) begin
                data_d = RESET_VAL;
            end
        end else if (en_i) begin
            valid_d = valid_i;
            data_d  = data_i;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= 1'b0;
            data_q  <= RESET_VAL;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;

endmodule

// File: rtl/pipe_reg_chain.sv
// rtl/pipe_reg_chain.sv - DEPTH-stage valid-qualified register chain with stall, flush and occupancy
module pipe_reg_chain
    import pipe_reg_chain_pkg::*;
#(
    parameter int               WIDTH      = WORD,
    parameter int               DEPTH      = 1,
    parameter logic [WIDTH-1:0] RESET_VAL  = '0,
    parameter bit               FLUSH_DATA = 1'b1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       en,
    input  logic                       flush,
    input  logic                       valid_in,
    input  logic [WIDTH-1:0]           D,
    output logic [WIDTH-1:0]           Q,
    output logic                       valid_out,
    output logic [occ_w(DEPTH)-1:0]    occ
);

    localparam int OW = occ_w(DEPTH);

    if (DEPTH < 1 || DEPTH > PIPE_MAX_DEPTH) begin : g_bad_depth
        $error("pipe_reg_chain: DEPTH out of range");
    end

    logic             stage_valid [DEPTH];
    logic [WIDTH-1:0] stage_data  [DEPTH];

    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
        logic             in_valid;
        logic [WIDTH-1:0] in_data;

        if (i == 0) begin : g_head
            assign in_valid = valid_in;
            assign in_data  = D;
        end else begin : g_body
            assign in_valid = stage_valid[i-1];
            assign in_data  = stage_data[i-1];
        end

        pipe_stage #(
            .WIDTH      (WIDTH),
            .RESET_VAL  (RESET_VAL),
            .FLUSH_DATA (FLUSH_DATA)
        ) u_stage (
            .clk     (clk),
            .reset   (reset),
            .en_i    (en),
            .flush_i (flush),
            .valid_i (in_valid),
            .data_i  (in_data),
            .valid_o (stage_valid[i]),
            .data_o  (stage_data[i])
        );
    end

    logic [OW-1:0] occ_q, occ_d;

    // One entry may enter and one may leave per shift, so occ stays within 0..DEPTH.
    always_comb begin
        occ_d = occ_q;
        if (flush) begin
            occ_d = '0;
        end else if (en) begin
            occ_d = occ_q + OW'(valid_in) - OW'(stage_valid[DEPTH-1]);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            occ_q <= '0;
        end else begin
            occ_q <= occ_d;
        end
    end

    assign Q         = stage_data[DEPTH-1];
    assign valid_out = stage_valid[DEPTH-1];
    assign occ       = occ_q;

endmodule

// File: tb/tb_pipe_reg_chain.sv
// tb/tb_pipe_reg_chain.sv - scoreboard bench for pipe_reg_chain, DEPTH=3, both flush modes
module tb_pipe_reg_chain;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        en = 1'b0;
    logic        flush = 1'b0;
    logic        valid_in = 1'b0;
    logic [31:0] D = '0;
    logic [31:0] q_a, q_b;
    logic        v_a, v_b;
    logic [1:0]  occ_a, occ_b;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pipe_reg_chain #(.WIDTH(32), .DEPTH(3), .RESET_VAL(32'd0), .FLUSH_DATA(1'b1)) dut_a (
        .clk(clk), .reset(reset), .en(en), .flush(flush), .valid_in(valid_in),
        .D(D), .Q(q_a), .valid_out(v_a), .occ(occ_a)
    );

    pipe_reg_chain #(.WIDTH(32), .DEPTH(3), .RESET_VAL(32'd0), .FLUSH_DATA(1'b0)) dut_b (
        .clk(clk), .reset(reset), .en(en), .flush(flush), .valid_in(valid_in),
        .D(D), .Q(q_b), .valid_out(v_b), .occ(occ_b)
    );

    typedef struct packed {
        logic        rst;
        logic        fl;
        logic        en;
        logic        vi;
        logic [31:0] d;
        logic        mid;
        logic [31:0] early;
        logic [31:0] q;
        logic        v;
        logic [1:0]  occ;
        logic [31:0] q2;
    } vec_t;

    typedef struct packed {
        int          step;
        logic [31:0] q;
        logic        v;
        logic [1:0]  occ;
        logic [31:0] q2;
    } exp_t;

    vec_t vecs[$];
    exp_t exp_q[$];

    task automatic add(input logic rst, input logic fl, input logic e, input logic vi,
                       input logic [31:0] d, input logic mid, input logic [31:0] early,
                       input logic [31:0] q, input logic v, input logic [1:0] o,
                       input logic [31:0] q2);
        vec_t t;
        t = '{rst, fl, e, vi, d, mid, early, q, v, o, q2};
        vecs.push_back(t);
    endtask

    task automatic chk32(input string name, input int step, input logic [31:0] got,
                         input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s step %0d: got %h want %h", name, step, got, want);
        end
    endtask

    // Monitor: outputs are sampled on the falling edge after each driven rising edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk32("q_a",   e.step, q_a,          e.q);
                chk32("v_a",   e.step, {31'd0, v_a}, {31'd0, e.v});
                chk32("occ_a", e.step, {30'd0, occ_a}, {30'd0, e.occ});
                chk32("q_b",   e.step, q_b,          e.q2);
                chk32("v_b",   e.step, {31'd0, v_b}, {31'd0, e.v});
                chk32("occ_b", e.step, {30'd0, occ_b}, {30'd0, e.occ});
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not end, got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e;
        //   rst fl en vi  D             mid early   Q             v occ Q2
        add(1, 0, 0, 0, 32'd0,         0, 0,      32'd0,         0, 0, 32'd0);
        // reset then stream
        add(0, 0, 1, 1, 32'd1,         0, 0,      32'd0,         0, 1, 32'd0);
        add(0, 0, 1, 1, 32'd2,         0, 0,      32'd0,         0, 2, 32'd0);
        add(0, 0, 1, 1, 32'd3,         0, 0,      32'd1,         1, 3, 32'd1);
        add(0, 0, 1, 1, 32'd4,         0, 0,      32'd2,         1, 3, 32'd2);
        // mid-cycle change: 40 is overwritten by 5 before the edge
        add(0, 0, 1, 1, 32'd5,         1, 32'd40, 32'd3,         1, 3, 32'd3);
        add(0, 0, 1, 1, 32'd6,         0, 0,      32'd4,         1, 3, 32'd4);
        add(0, 0, 1, 1, 32'd7,         0, 0,      32'd5,         1, 3, 32'd5);
        // stream then stall with D=99
        add(0, 0, 1, 1, 32'd10,        0, 0,      32'd6,         1, 3, 32'd6);
        add(0, 0, 1, 1, 32'd11,        0, 0,      32'd7,         1, 3, 32'd7);
        add(0, 0, 1, 1, 32'd12,        0, 0,      32'd10,        1, 3, 32'd10);
        add(0, 0, 0, 1, 32'd99,        0, 0,      32'd10,        1, 3, 32'd10);
        add(0, 0, 0, 1, 32'd99,        0, 0,      32'd10,        1, 3, 32'd10);
        add(0, 0, 1, 1, 32'd13,        0, 0,      32'd11,        1, 3, 32'd11);
        add(0, 0, 1, 1, 32'd14,        0, 0,      32'd12,        1, 3, 32'd12);
        // flush with en=0 on a full chain; dut_b keeps its data
        add(0, 1, 0, 1, 32'd55,        0, 0,      32'd0,         0, 0, 32'd12);
        add(0, 0, 1, 1, 32'd20,        0, 0,      32'd0,         0, 1, 32'd13);
        add(0, 0, 1, 1, 32'd21,        0, 0,      32'd0,         0, 2, 32'd14);
        add(0, 0, 1, 1, 32'd22,        0, 0,      32'd20,        1, 3, 32'd20);
        // reset beats flush and en; 29 is not captured
        add(1, 1, 1, 1, 32'd29,        0, 0,      32'd0,         0, 0, 32'd0);
        add(0, 0, 1, 1, 32'd30,        0, 0,      32'd0,         0, 1, 32'd0);
        add(0, 0, 1, 1, 32'd31,        0, 0,      32'd0,         0, 2, 32'd0);
        add(0, 0, 1, 1, 32'd32,        0, 0,      32'd30,        1, 3, 32'd30);
        // bubbles and full-width data
        add(0, 0, 1, 1, 32'hFFFFFFFF,  0, 0,      32'd31,        1, 3, 32'd31);
        add(0, 0, 1, 0, 32'd7,         0, 0,      32'd32,        1, 2, 32'd32);
        add(0, 0, 1, 1, 32'h80000000,  0, 0,      32'hFFFFFFFF,  1, 2, 32'hFFFFFFFF);
        add(0, 0, 1, 0, 32'd0,         0, 0,      32'd7,         0, 1, 32'd7);
        add(0, 0, 1, 0, 32'd0,         0, 0,      32'h80000000,  1, 1, 32'h80000000);
        add(0, 0, 1, 0, 32'd0,         0, 0,      32'd0,         0, 0, 32'd0);
        add(0, 0, 1, 0, 32'd1,         0, 0,      32'd0,         0, 0, 32'd0);
        // flush with en=1 on a partly filled chain; 77 is dropped
        add(0, 0, 1, 1, 32'd50,        0, 0,      32'd0,         0, 1, 32'd0);
        add(0, 1, 1, 1, 32'd77,        0, 0,      32'd0,         0, 0, 32'd0);
        add(0, 0, 1, 1, 32'd60,        0, 0,      32'd0,         0, 1, 32'd1);
        add(0, 0, 1, 1, 32'd61,        0, 0,      32'd0,         0, 2, 32'd50);
        add(0, 0, 1, 1, 32'd62,        0, 0,      32'd60,        1, 3, 32'd60);

        #1;
        for (int i = 0; i < vecs.size(); i++) begin
            reset    = vecs[i].rst;
            flush    = vecs[i].fl;
            en       = vecs[i].en;
            valid_in = vecs[i].vi;
            if (vecs[i].mid) begin
                D = vecs[i].early;
                #2;
            end
            D = vecs[i].d;
            @(posedge clk);
            e = '{i, vecs[i].q, vecs[i].v, vecs[i].occ, vecs[i].q2};
            exp_q.push_back(e);
            #1;
        end
        en       = 1'b0;
        valid_in = 1'b0;
        repeat (2) @(posedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending want 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
